mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- MEM/WB pipeline stage of the LEGv8 pipeline, directly downstream of the MEM stage.
- Captures the MEM stage's control/result bundle into a 2-entry skid buffer and selects the writeback value (memory data vs ALU result).
- Drives the register-file write port, which is arbitrated and can backpressure.
- Exposes two forwarding query ports so decode/EX can bypass pending writebacks.

Parameters:
- DATA_W, 64, datapath width.
- REG_AW, 5, register address width.
- ZERO_REG, 31, XZR index; writes to it are discarded.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  MEM bundle valid.
- in_ready  out  1  stage can accept a bundle.
- RegWrite  in  1  bundle writes the register file.
- MemtoReg  in  1  1 selects ReadData, 0 selects ALUResult.
- WriteReg  in  REG_AW  destination register.
- ALUResult  in  DATA_W  ALU result from MEM.
- ReadData  in  DATA_W  data-memory read value from MEM.
- rf_we  out  1  register-file write request.
- rf_waddr  out  REG_AW  write address.
- rf_wdata  out  DATA_W  write data.
- rf_gnt  in  1  write port granted this cycle.
- q0_reg  in  REG_AW  forwarding query 0 register.
- q0_hit  out  1  a pending entry matches q0_reg.
- q0_data  out  DATA_W  forwarded value for q0.
- q1_reg  in  REG_AW  forwarding query 1 register.
- q1_hit  out  1  a pending entry matches q1_reg.
- q1_data  out  DATA_W  forwarded value for q1.

Behaviour:
- Storage: head entry H (older) and skid entry S (younger). Each entry holds valid, we, waddr, wdata.
- Capture:
  - wdata = MemtoReg ? ReadData : ALUResult, computed at capture.
  - we = RegWrite && (WriteReg != ZERO_REG).
- in_ready = !S.valid, driven from a flop only; no combinational path from rf_gnt.
- Accept = in_valid && in_ready. Data is registered, 1-cycle latency: accepted at edge N, visible at rf_* in cycle N+1 at the earliest.
- Retire (pop H) when H.valid && (!H.we || rf_gnt). Entries with we=0 retire in 1 cycle without needing a grant.
- rf_we = H.valid && H.we. rf_waddr and rf_wdata follow H. These outputs are combinational from state only.
- State machine (occupancy):
  - EMPTY:
    - Accept -> ONE (bundle into H).
  - ONE:
    - Accept and retire -> ONE (new bundle into H).
    - Accept only -> TWO (new bundle into S).
    - Retire only -> EMPTY.
  - TWO:
    - Retire -> ONE (S moves to H). A simultaneous accept is impossible because in_ready=0.
    - No retire -> TWO (hold).
- Forwarding, per query port:
  - hit if S matches (valid, we, waddr == q) or H matches.
  - S (younger) wins when both match; data comes from the winning entry.
  - Query of ZERO_REG never hits.
  - Combinational; reflects the current cycle's state, not same-cycle inputs.
- While rf_we is held without a grant, H is stable: rf_waddr and rf_wdata must not change until granted.
- Reset, async on reset_n low:
  - All valid bits cleared, which forces rf_we=0, q*_hit=0 and in_ready=1.
  - Data fields are cleared to 0.
  - Reset mid-stall discards pending entries. On release the stage is EMPTY.
- X-safety: data fields of invalid entries never affect any output.

Optional Feature:
- Macro WB_RETIRE_CNT_EN.
- Defined:
  - Adds output retire_count [63:0], reset to 0.
  - Increments by 1 on every retire, including we=0 entries; wraps modulo 2^64.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package legv8_pkg:
  - DATA_W and REG_AW constants.
  - XZR constant (31).
  - Typedef wb_entry_t {valid, we, waddr, wdata}.
- One sub-module, wb_skid_buf: the 2-entry H/S buffer with the valid/ready and retire logic.
- Writeback mux, XZR filter and forwarding comparators stay in mem_wb_stage.

Test Plan:
- ALU write: RegWrite=1, MemtoReg=0, WriteReg=3, ALUResult=0x10, rf_gnt=1 -> next cycle rf_we=1, rf_waddr=3, rf_wdata=0x10; following cycle rf_we=0.
- Load select: MemtoReg=1, ReadData=0xDEAD, ALUResult=0x5, WriteReg=7 -> rf_wdata=0xDEAD.
- XZR and no-write: WriteReg=31 with RegWrite=1, or RegWrite=0 -> rf_we stays 0, entry retires without grant, q0_reg=31 gives q0_hit=0.
- Backpressure: rf_gnt=0 with 3 back-to-back writes (X1=1, X2=2, X3=3) -> in_ready falls after the 2nd accept; X3 is held by MEM; rf_gnt=1 then retires 1, 2, 3 in order with no loss.
- Forwarding priority: H={X5=0xA}, S={X5=0xB}, q1_reg=5 -> q1_hit=1, q1_data=0xB.
- Reset mid-stall: TWO entries, rf_gnt=0, reset_n pulsed low -> immediately rf_we=0, in_ready=1, q*_hit=0. With WB_RETIRE_CNT_EN, retire_count=0.

Source files
------------

// File: rtl/legv8_pkg.sv
// Shared LEGv8 pipeline constants and the MEM/WB writeback entry type.
package legv8_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned XZR    = 31;

    // One pending writeback: valid slot, register-write enable, address and data.
    typedef struct packed {
        logic              valid;
        logic              we;
        logic [REG_AW-1:0] waddr;
        logic [DATA_W-1:0] wdata;
    } wb_entry_t;

endpackage

// File: rtl/wb_skid_buf.sv
// Two-entry head/skid buffer for MEM/WB writebacks.
// The head entry (older) drives the register-file port; the skid entry (younger)
// absorbs one extra bundle while the head waits for a write grant.
module wb_skid_buf
    import legv8_pkg::*;
(
    input  logic      clock,
    input  logic      reset_n,
    input  logic      in_valid,
    output logic      in_ready,
    input  wb_entry_t in_entry,
    input  logic      rf_gnt,
    output wb_entry_t head,
    output wb_entry_t skid
);

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} occ_e;

    occ_e      state_q, state_d;
    wb_entry_t head_q, head_d;
    wb_entry_t skid_q, skid_d;
    logic      in_ready_q;
    logic      accept;
    logic      retire;
    wb_entry_t new_e;

    // Handshake decode; ready comes straight from a flop so rf_gnt never reaches it.
    always_comb begin
        accept      = in_valid && in_ready_q;
        retire      = head_q.valid && (!head_q.we || rf_gnt);
        new_e       = in_entry;
        new_e.valid = 1'b1;
    end

    // Occupancy FSM: next state and next contents of both slots.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    head_d  = new_e;
                    state_d = StOne;
                end
            end
            StOne: begin
                if (accept && retire) begin
                    head_d = new_e;
                end else if (accept) begin
                    skid_d  = new_e;
                    state_d = StTwo;
                end else if (retire) begin
                    head_d  = '0;
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                // in_ready is low here, so no accept can coincide with the pop.
                if (retire) begin
                    head_d  = skid_q;
                    skid_d  = '0;
                    state_d = StOne;
                end
            end
            default: begin
                head_d  = '0;
                skid_d  = '0;
                state_d = StEmpty;
            end
        endcase
    end

    // State registers; reset discards anything pending and reopens the input.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StEmpty;
            head_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != StTwo);
        end
    end

    // Expose registered state only.
    always_comb begin
        in_ready = in_ready_q;
        head     = head_q;
        skid     = skid_q;
    end

endmodule

// File: rtl/mem_wb_stage.sv
// LEGv8 MEM/WB stage: selects the writeback value, filters XZR writes, buffers
// bundles in a 2-entry skid buffer feeding an arbitrated register-file port,
// and answers two forwarding queries against pending writebacks.
// Optional: define WB_RETIRE_CNT_EN to add a 64-bit retire counter output.
module mem_wb_stage #(
    parameter int unsigned DATA_W   = legv8_pkg::DATA_W,
    parameter int unsigned REG_AW   = legv8_pkg::REG_AW,
    parameter int unsigned ZERO_REG = legv8_pkg::XZR
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              RegWrite,
    input  logic              MemtoReg,
    input  logic [REG_AW-1:0] WriteReg,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic [DATA_W-1:0] ReadData,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic              rf_gnt,
    input  logic [REG_AW-1:0] q0_reg,
    output logic              q0_hit,
    output logic [DATA_W-1:0] q0_data,
    input  logic [REG_AW-1:0] q1_reg,
    output logic              q1_hit,
    output logic [DATA_W-1:0] q1_data
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [63:0]       retire_count
`endif
);

    import legv8_pkg::*;

    localparam logic [REG_AW-1:0] ZeroAddr = REG_AW'(ZERO_REG);

    wb_entry_t in_entry;
    wb_entry_t head;
    wb_entry_t skid;

    // Writeback mux and XZR filter, resolved before the bundle is stored.
    always_comb begin
        in_entry.valid = 1'b1;
        in_entry.we    = RegWrite && (WriteReg != ZeroAddr);
        in_entry.waddr = WriteReg;
        in_entry.wdata = MemtoReg ? ReadData : ALUResult;
    end

    wb_skid_buf u_skid_buf (
        .clock    (clock),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_entry (in_entry),
        .rf_gnt   (rf_gnt),
        .head     (head),
        .skid     (skid)
    );

    // Register-file port follows the head; fields gated so stale data never leaks.
    always_comb begin
        rf_we    = head.valid && head.we;
        rf_waddr = head.valid ? head.waddr : '0;
        rf_wdata = head.valid ? head.wdata : '0;
    end

    function automatic logic fwd_match(input wb_entry_t e, input logic [REG_AW-1:0] q);
        return e.valid && e.we && (e.waddr == q) && (q != ZeroAddr);
    endfunction

    // Forwarding query 0: the younger skid entry wins over the head.
    always_comb begin
        q0_hit  = 1'b0;
        q0_data = '0;
        if (fwd_match(skid, q0_reg)) begin
            q0_hit  = 1'b1;
            q0_data = skid.wdata;
        end else if (fwd_match(head, q0_reg)) begin
            q0_hit  = 1'b1;
            q0_data = head.wdata;
        end
    end

    // Forwarding query 1: same priority as query 0.
    always_comb begin
        q1_hit  = 1'b0;
        q1_data = '0;
        if (fwd_match(skid, q1_reg)) begin
            q1_hit  = 1'b1;
            q1_data = skid.wdata;
        end else if (fwd_match(head, q1_reg)) begin
            q1_hit  = 1'b1;
            q1_data = head.wdata;
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic        retire;
    logic [63:0] retire_count_q;

    // Pop condition mirrored from the buffer; non-writing entries count too.
    always_comb begin
        retire = head.valid && (!head.we || rf_gnt);
    end

    // Free-running retire counter, wraps naturally at 2^64.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            retire_count_q <= '0;
        end else if (retire) begin
            retire_count_q <= retire_count_q + 64'd1;
        end
    end

    always_comb begin
        retire_count = retire_count_q;
    end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus randomized traffic,
// checked by a queue-level reference model and a write scoreboard.
module tb_mem_wb_stage;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        RegWrite = 1'b0;
    logic        MemtoReg = 1'b0;
    logic [4:0]  WriteReg = '0;
    logic [63:0] ALUResult = '0;
    logic [63:0] ReadData = '0;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic        rf_gnt = 1'b0;
    logic [4:0]  q0_reg = '0;
    logic        q0_hit;
    logic [63:0] q0_data;
    logic [4:0]  q1_reg = '0;
    logic        q1_hit;
    logic [63:0] q1_data;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_count;
`endif

    mem_wb_stage dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .RegWrite  (RegWrite),
        .MemtoReg  (MemtoReg),
        .WriteReg  (WriteReg),
        .ALUResult (ALUResult),
        .ReadData  (ReadData),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .rf_gnt    (rf_gnt),
        .q0_reg    (q0_reg),
        .q0_hit    (q0_hit),
        .q0_data   (q0_data),
        .q1_reg    (q1_reg),
        .q1_hit    (q1_hit),
        .q1_data   (q1_data)
`ifdef WB_RETIRE_CNT_EN
        ,
        .retire_count (retire_count)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        bit        we;
        bit [4:0]  a;
        bit [63:0] d;
    } pend_t;

    pend_t           pend[$];   // every accepted bundle still in the stage, oldest first
    pend_t           expw[$];   // scoreboard of expected register-file writes
    int              checks = 0;
    int              failures = 0;
    longint unsigned exp_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Youngest matching pending write supplies the forwarded value; XZR never hits.
    function automatic void fwd(input bit [4:0] q, output bit hit, output bit [63:0] d);
        hit = 0;
        d   = '0;
        if (q != 5'd31) begin
            for (int i = 0; i < pend.size(); i++) begin
                if (pend[i].we && pend[i].a == q) begin
                    hit = 1;
                    d   = pend[i].d;
                end
            end
        end
    endfunction

    // Reference model: stage holds at most two bundles, retires oldest in order.
    always @(posedge clock or negedge reset_n) begin
        bit    acc;
        pend_t e;
        if (!reset_n) begin
            pend.delete();
            expw.delete();
            exp_cnt = 0;
        end else begin
            acc = in_valid && (pend.size() < 2);
            if (pend.size() > 0 && (!pend[0].we || rf_gnt)) begin
                void'(pend.pop_front());
                exp_cnt++;
            end
            if (acc) begin
                e.we = RegWrite && (WriteReg != 5'd31);
                e.a  = WriteReg;
                e.d  = MemtoReg ? ReadData : ALUResult;
                pend.push_back(e);
                if (e.we) expw.push_back(e);
            end
        end
    end

    // Monitor: compares DUT outputs on the falling edge against the model.
    always @(negedge clock) begin
        bit        eh;
        bit [63:0] ed;
        check("in_ready", in_ready, (pend.size() < 2));
        check("rf_we", rf_we, (pend.size() > 0) && pend[0].we);
        if (rf_we) begin
            if (expw.size() == 0) begin
                check("unexpected_write", 1'b1, 1'b0);
            end else begin
                check("rf_waddr", rf_waddr, expw[0].a);
                check("rf_wdata", rf_wdata, expw[0].d);
                if (rf_gnt) void'(expw.pop_front());
            end
        end
        fwd(q0_reg, eh, ed);
        check("q0_hit", q0_hit, eh);
        if (eh) check("q0_data", q0_data, ed);
        fwd(q1_reg, eh, ed);
        check("q1_hit", q1_hit, eh);
        if (eh) check("q1_data", q1_data, ed);
`ifdef WB_RETIRE_CNT_EN
        check("retire_count", retire_count, exp_cnt);
`endif
    end

    task automatic drive(input bit rw, input bit m2r, input bit [4:0] wr,
                         input bit [63:0] alu, input bit [63:0] rd);
        in_valid  = 1'b1;
        RegWrite  = rw;
        MemtoReg  = m2r;
        WriteReg  = wr;
        ALUResult = alu;
        ReadData  = rd;
    endtask

    // Holds the bundle until the model says it was taken; bounded wait.
    task automatic send(input bit rw, input bit m2r, input bit [4:0] wr,
                        input bit [63:0] alu, input bit [63:0] rd);
        bit acc;
        int n;
        n = 0;
        drive(rw, m2r, wr, alu, rd);
        do begin
            @(negedge clock);
            acc = (pend.size() < 2);
            @(posedge clock);
            #1;
            n++;
        end while (!acc && n < 50);
        if (!acc) check("send_timeout", 1'b0, 1'b1);
        in_valid = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;

        // ALU result write, granted immediately.
        rf_gnt = 1'b1;
        send(1, 0, 5'd3, 64'h10, 64'h0);
        @(negedge clock);
        check("alu_we", rf_we, 1'b1);
        check("alu_waddr", rf_waddr, 64'd3);
        check("alu_wdata", rf_wdata, 64'h10);
        @(negedge clock);
        check("alu_we_after", rf_we, 1'b0);
        @(posedge clock); #1;

        // Load selects memory data.
        send(1, 1, 5'd7, 64'h5, 64'hDEAD);
        @(negedge clock);
        check("load_wdata", rf_wdata, 64'hDEAD);
        @(posedge clock); #1;

        // XZR destination and RegWrite=0 retire without a grant.
        rf_gnt = 1'b0;
        q0_reg = 5'd31;
        send(1, 0, 5'd31, 64'h99, 64'h0);
        @(negedge clock);
        check("xzr_we", rf_we, 1'b0);
        check("xzr_q0_hit", q0_hit, 1'b0);
        @(posedge clock); #1;
        send(0, 0, 5'd4, 64'h44, 64'h0);
        @(negedge clock);
        check("nowrite_we", rf_we, 1'b0);
        @(negedge clock);
        check("nowrite_ready", in_ready, 1'b1);
        @(posedge clock); #1;

        // Backpressure: two writes stall, third held by MEM until grant.
        send(1, 0, 5'd1, 64'h1, 64'h0);
        send(1, 0, 5'd2, 64'h2, 64'h0);
        drive(1, 0, 5'd3, 64'h3, 64'h0);
        @(negedge clock);
        check("bp_ready_low", in_ready, 1'b0);
        repeat (3) @(posedge clock);
        #1 rf_gnt = 1'b1;
        send(1, 0, 5'd3, 64'h3, 64'h0);
        repeat (4) @(posedge clock);
        #1;
        check("bp_drained", expw.size(), 64'd0);

        // Forwarding priority: younger skid entry wins.
        rf_gnt = 1'b0;
        q1_reg = 5'd5;
        send(1, 0, 5'd5, 64'hA, 64'h0);
        send(1, 0, 5'd5, 64'hB, 64'h0);
        @(negedge clock);
        check("fwd_hit", q1_hit, 1'b1);
        check("fwd_data", q1_data, 64'hB);

        // Reset mid-stall with two entries pending.
        q0_reg = 5'd5;
        #1 reset_n = 1'b0;
        #1;
        check("rst_we", rf_we, 1'b0);
        check("rst_ready", in_ready, 1'b1);
        check("rst_q0_hit", q0_hit, 1'b0);
        check("rst_q1_hit", q1_hit, 1'b0);
`ifdef WB_RETIRE_CNT_EN
        check("rst_count", retire_count, 64'd0);
`endif
        #1 reset_n = 1'b1;
        @(posedge clock); #1;

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            RegWrite  = ($urandom_range(0, 4) != 0);
            MemtoReg  = $urandom_range(0, 1);
            WriteReg  = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            ALUResult = {$urandom, $urandom};
            ReadData  = {$urandom, $urandom};
            rf_gnt    = ($urandom_range(0, 2) != 0);
            q0_reg    = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            q1_reg    = 5'($urandom_range(0, 7));
            @(posedge clock); #1;
        end

        in_valid = 1'b0;
        rf_gnt   = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        check("final_drain", expw.size(), 64'd0);
        check("final_empty", pend.size(), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
